// File: rtl/kbd_scancode_fifo.sv
// PS/2 scancode FIFO for the OTTER IOBUS: edge-captures driver strobes, optionally drops
// break sequences, exposes head/status as read ports, and pulses INTR when a new head appears.
module kbd_scancode_fifo #(
    parameter int unsigned DEPTH        = 8,
    parameter logic [31:0] BASE_AD      = 32'h1100_0100,
    parameter logic        FILTER_BREAK = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        KBD_VALID,
    input  logic [7:0]  KBD_CODE,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RDATA,
    output logic        INTR
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] STAT_AD = BASE_AD + 32'd4;
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_SKIP = 1'b1;

    logic             kbd_valid_q;
    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             intr_q, intr_d;
    logic [7:0]       mem_q [DEPTH];

    logic capture, accept, do_push, do_pop, ovf_set, ovf_clr;
    logic empty, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // Capture, break filter, pointer/count/flag next-state and interrupt generation
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        intr_d  = 1'b0;

        capture = KBD_VALID & ~kbd_valid_q;
        accept  = capture;
        do_pop  = IOBUS_WR && (IOBUS_ADDR == BASE_AD) && !empty;
        ovf_clr = IOBUS_WR && (IOBUS_ADDR == STAT_AD) && IOBUS_OUT[0];

        if (FILTER_BREAK && capture) begin
            case (state_q)
                ST_PASS: begin
                    if (KBD_CODE == BREAK_CODE) begin
                        state_d = ST_SKIP;
                        accept  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_PASS;
                    accept  = 1'b0;
                end
            endcase
        end

        // A pop in the same cycle frees the slot a full-FIFO push needs
        do_push = accept && (!full || do_pop);
        ovf_set = accept && full && !do_pop;

        if (do_push) wp_d = wp_q + PTR_W'(1);
        if (do_pop)  rp_d = rp_q + PTR_W'(1);

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;

        intr_d = (do_push && empty) || (do_pop && (do_push || (count_q > CNT_W'(1))));
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            kbd_valid_q <= 1'b0;
            state_q     <= ST_PASS;
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            kbd_valid_q <= KBD_VALID;
            state_q     <= state_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            intr_q      <= intr_d;
        end
    end

    // Storage needs no reset; empty masks stale contents
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wp_q] <= KBD_CODE;
    end

    always_comb begin
        RDATA = '0;
        if (IOBUS_ADDR == BASE_AD) begin
            RDATA = empty ? 32'd0 : {24'd0, mem_q[rp_q]};
        end else if (IOBUS_ADDR == STAT_AD) begin
            RDATA = {21'd0, ovf_q, full, empty, 8'(count_q)};
        end
    end

    assign INTR = intr_q;

endmodule
